// File: rtl/arb_pkg.sv
// Shared definitions for the unified I/D memory port arbiter: FSM encoding,
// requester IDs, legal parameter bounds and small helpers.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } arbState_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int RD_LAT_MIN     = 1;
   localparam int RD_LAT_MAX     = 4;
   localparam int STARVE_MAX_MIN = 1;
   localparam int STARVE_MAX_MAX = 15;

   // Widths sized to hold RD_LAT_MAX-1 and STARVE_MAX_MAX
   localparam int LAT_CNT_W    = 2;
   localparam int STARVE_CNT_W = 4;

   function automatic logic [31:0] satInc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/arb_read_tracker.sv
// Read-latency tracker: counts down the fixed memory latency, captures the
// returned word into the owning requester's held register and pulses RValid.
module arb_read_tracker
   import arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iStart,
   input  logic              iWait,
   input  logic              iWaitId,
   input  logic [DATA_W-1:0] iM_ReadData,
   output logic              oDone,
   output logic              oI_RValid,
   output logic [DATA_W-1:0] oI_RData,
   output logic              oD_RValid,
   output logic [DATA_W-1:0] oD_RData
);

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

   logic [LAT_CNT_W-1:0] latCnt;

   // Last WAIT cycle: memory data is on iM_ReadData right now
   assign oDone = iWait && (latCnt == '0);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         latCnt <= '0;
      end else if (iStart) begin
         latCnt <= LAT_LOAD;
      end else if (iWait && (latCnt != '0)) begin
         latCnt <= latCnt - 1'b1;
      end
   end

   // One capture slot per requester, indexed by requester ID
   for (genvar gi = 0; gi < 2; gi++) begin : gCap
      logic              rValid;
      logic [DATA_W-1:0] rData;
      logic              hit;

      assign hit = oDone && (iWaitId == 1'(gi));

      always_ff @(posedge iCLK) begin
         if (iRST) begin
            rValid <= 1'b0;
            rData  <= '0;
         end else begin
            rValid <= hit;
            if (hit) begin
               rData <= iM_ReadData;
            end
         end
      end
   end

   assign oI_RValid = gCap[0].rValid;
   assign oI_RData  = gCap[0].rData;
   assign oD_RValid = gCap[1].rValid;
   assign oD_RData  = gCap[1].rData;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D);
// D has priority, a starvation counter forces I through. Option: ARB_PERF_CNT_EN.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic                iI_Req,
   input  logic [ADDR_W-1:0]   iI_Addr,
   output logic                oI_Gnt,
   output logic                oI_RValid,
   output logic [DATA_W-1:0]   oI_RData,
   input  logic                iD_Req,
   input  logic                iD_We,
   input  logic [DATA_W/8-1:0] iD_Be,
   input  logic [ADDR_W-1:0]   iD_Addr,
   input  logic [DATA_W-1:0]   iD_WData,
   output logic                oD_Gnt,
   output logic                oD_RValid,
   output logic [DATA_W-1:0]   oD_RData,
   output logic                oM_ReadEnable,
   output logic                oM_WriteEnable,
   output logic [DATA_W/8-1:0] oM_ByteEnable,
   output logic [ADDR_W-1:0]   oM_Address,
   output logic [DATA_W-1:0]   oM_WriteData,
   input  logic [DATA_W-1:0]   iM_ReadData,
   output logic                oBusy
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]         oI_StallCnt,
   output logic [31:0]         oD_StallCnt
`endif
);

   if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : gBadLat
      $error("mem_port_arbiter: RD_LAT out of range 1..4");
   end
   if ((STARVE_MAX < STARVE_MAX_MIN) || (STARVE_MAX > STARVE_MAX_MAX)) begin : gBadStarve
      $error("mem_port_arbiter: STARVE_MAX out of range 1..15");
   end

   localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

   arbState_t               state, stateNext;
   logic [STARVE_CNT_W-1:0] starveCnt;
   logic                    canGrant, gntI, gntD, readStart, trkDone, waiting, waitId;

   // Grants are suppressed while reset is held so nothing leaks onto the bus
   assign canGrant  = (state == IDLE) && !iRST;
   assign gntD      = canGrant && iD_Req && (starveCnt < STARVE_LIM);
   assign gntI      = canGrant && iI_Req && !gntD;
   assign readStart = (gntD && !iD_We) || gntI;
   assign waiting   = (state == WAIT_I) || (state == WAIT_D);
   assign waitId    = (state == WAIT_D) ? REQ_D : REQ_I;

   assign oI_Gnt = gntI;
   assign oD_Gnt = gntD;
   assign oBusy  = (state != IDLE);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext      = state;
      oM_ReadEnable  = 1'b0;
      oM_WriteEnable = 1'b0;
      oM_ByteEnable  = '0;
      oM_Address     = '0;
      oM_WriteData   = '0;
      case (state)
         IDLE: begin
            if (gntD) begin
               oM_ReadEnable  = !iD_We;
               oM_WriteEnable = iD_We;
               oM_ByteEnable  = iD_Be;
               oM_Address     = iD_Addr;
               oM_WriteData   = iD_WData;
               // Writes finish in the grant cycle; only reads wait
               if (!iD_We) begin
                  stateNext = WAIT_D;
               end
            end else if (gntI) begin
               oM_ReadEnable = 1'b1;
               oM_ByteEnable = '1;
               oM_Address    = iI_Addr;
               stateNext     = WAIT_I;
            end
         end
         WAIT_I, WAIT_D: begin
            if (trkDone) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         starveCnt <= '0;
      end else if (iI_Req && !gntI) begin
         if (starveCnt != STARVE_LIM) begin
            starveCnt <= starveCnt + 1'b1;
         end
      end else begin
         starveCnt <= '0;
      end
   end

   arb_read_tracker #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) uTracker (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iStart      (readStart),
      .iWait       (waiting),
      .iWaitId     (waitId),
      .iM_ReadData (iM_ReadData),
      .oDone       (trkDone),
      .oI_RValid   (oI_RValid),
      .oI_RData    (oI_RData),
      .oD_RValid   (oD_RValid),
      .oD_RData    (oD_RData)
   );

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oI_StallCnt <= '0;
         oD_StallCnt <= '0;
      end else begin
         if (iI_Req && !gntI) begin
            oI_StallCnt <= satInc32(oI_StallCnt);
         end
         if (iD_Req && !gntD) begin
            oD_StallCnt <= satInc32(oD_StallCnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1..3) share stimulus, each with its
// own fixed-latency memory model; expectations are hand-derived per test.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
   logic [3:0]  dBe = 4'h0;
   logic [31:0] iAddr = '0, dAddr = '0, dWData = '0;

   logic        iGnt [1:3], iRValid [1:3], dGnt [1:3], dRValid [1:3];
   logic        mRe [1:3], mWe [1:3], busy [1:3];
   logic [3:0]  mBe [1:3];
   logic [31:0] iRData [1:3], dRData [1:3], mAddr [1:3], mWData [1:3], mRData [1:3];
`ifdef ARB_PERF_CNT_EN
   logic [31:0] iStall [1:3], dStall [1:3];
`endif

   int errCnt = 0;
   int chkCnt = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0040_0000: return 32'hDEAD_BEEF;
         32'h0040_0004: return 32'h1357_9BDF;
         32'h1001_0000: return 32'hCAFE_F00D;
         default:       return a ^ 32'hA5A5_A5A5;
      endcase
   endfunction

   for (genvar gi = 1; gi <= 3; gi++) begin : gDut
      // Memory: data for a strobe in cycle T is presented only in cycle T+gi
      logic        pipeV [0:3] = '{default: 1'b0};
      logic [31:0] pipeD [0:3] = '{default: 32'h0};

      always @(posedge clk) begin
         pipeV[0] <= mRe[gi];
         pipeD[0] <= memWord(mAddr[gi]);
         for (int k = 1; k < 4; k++) begin
            pipeV[k] <= pipeV[k-1];
            pipeD[k] <= pipeD[k-1];
         end
      end
      assign mRData[gi] = pipeV[gi-1] ? pipeD[gi-1] : 32'h0;

      mem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .RD_LAT(gi), .STARVE_MAX(4)
      ) dut (
         .iCLK(clk), .iRST(rst),
         .iI_Req(iReq), .iI_Addr(iAddr), .oI_Gnt(iGnt[gi]),
         .oI_RValid(iRValid[gi]), .oI_RData(iRData[gi]),
         .iD_Req(dReq), .iD_We(dWe), .iD_Be(dBe), .iD_Addr(dAddr), .iD_WData(dWData),
         .oD_Gnt(dGnt[gi]), .oD_RValid(dRValid[gi]), .oD_RData(dRData[gi]),
         .oM_ReadEnable(mRe[gi]), .oM_WriteEnable(mWe[gi]), .oM_ByteEnable(mBe[gi]),
         .oM_Address(mAddr[gi]), .oM_WriteData(mWData[gi]), .iM_ReadData(mRData[gi]),
         .oBusy(busy[gi])
`ifdef ARB_PERF_CNT_EN
         , .oI_StallCnt(iStall[gi]), .oD_StallCnt(dStall[gi])
`endif
      );
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetPulse();
      rst  = 1'b1;
      iReq = 1'b0;
      dReq = 1'b0;
      dWe  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int expD [7] = '{1, 0, 1, 0, 0, 0, 1};
   int expI [7] = '{0, 0, 0, 0, 1, 0, 0};

   initial begin
      // Reset held two cycles with both requesters active
      rst = 1'b1; iReq = 1'b1; dReq = 1'b1; dWe = 1'b0; dBe = 4'hF;
      iAddr = 32'h0040_0000; dAddr = 32'h1001_0000;
      for (int c = 0; c < 2; c++) begin
         tick();
         #1;
         checkVal("rst_iGnt",   iGnt[2],   0);
         checkVal("rst_dGnt",   dGnt[2],   0);
         checkVal("rst_mRe",    mRe[2],    0);
         checkVal("rst_mAddr",  mAddr[2],  0);
         checkVal("rst_mBe",    mBe[2],    0);
         checkVal("rst_busy",   busy[2],   0);
         checkVal("rst_iRData", iRData[2], 0);
         checkVal("rst_dRData", dRData[2], 0);
      end
      rst = 1'b0;
      #1;
      checkVal("rel_dGnt", dGnt[2], 1);
      checkVal("rel_iGnt", iGnt[2], 0);

      // I-only read, RD_LAT=2
      resetPulse();
      iReq = 1'b1; iAddr = 32'h0040_0000;
      #1;
      checkVal("i2_gnt",   iGnt[2],  1);
      checkVal("i2_mRe",   mRe[2],   1);
      checkVal("i2_mAddr", mAddr[2], 32'h0040_0000);
      checkVal("i2_mBe",   mBe[2],   4'hF);
      tick();
      iReq = 1'b0;
      #1;
      checkVal("i2_busy", busy[2], 1);
      tick(); #1;
      checkVal("i2_early", iRValid[2], 0);
      tick(); #1;
      checkVal("i2_rvalid", iRValid[2], 1);
      checkVal("i2_rdata",  iRData[2],  32'hDEAD_BEEF);
      tick(); #1;
      checkVal("i2_pulse", iRValid[2], 0);
      checkVal("i2_held",  iRData[2],  32'hDEAD_BEEF);

      // Simultaneous I and D reads, RD_LAT=1
      resetPulse();
      iReq = 1'b1; iAddr = 32'h0040_0004;
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0000;
      #1;
      checkVal("sim_dGnt",  dGnt[1],  1);
      checkVal("sim_iGnt0", iGnt[1],  0);
      checkVal("sim_mAddr", mAddr[1], 32'h1001_0000);
      tick();
      dReq = 1'b0;
      #1;
      checkVal("sim_wait_iGnt", iGnt[1], 0);
      tick(); #1;
      checkVal("sim_dRValid", dRValid[1], 1);
      checkVal("sim_dRData",  dRData[1],  32'hCAFE_F00D);
      checkVal("sim_iGnt2",   iGnt[1],    1);
      checkVal("sim_iAddr",   mAddr[1],   32'h0040_0004);
      tick();
      iReq = 1'b0;
      tick(); #1;
      checkVal("sim_iRValid", iRValid[1], 1);
      checkVal("sim_iRData",  iRData[1],  32'h1357_9BDF);

      // D write, RD_LAT=1
      resetPulse();
      dReq = 1'b1; dWe = 1'b1; dBe = 4'b0011;
      dAddr = 32'h1001_0008; dWData = 32'h0000_ABCD;
      #1;
      checkVal("wr_gnt",   dGnt[1],   1);
      checkVal("wr_mWe",   mWe[1],    1);
      checkVal("wr_mRe",   mRe[1],    0);
      checkVal("wr_mBe",   mBe[1],    4'b0011);
      checkVal("wr_mAddr", mAddr[1],  32'h1001_0008);
      checkVal("wr_mData", mWData[1], 32'h0000_ABCD);
      tick(); #1;
      checkVal("wr_busy",   busy[1],    0);
      checkVal("wr_regnt",  dGnt[1],    1);
      checkVal("wr_rvalid", dRValid[1], 0);
      dReq = 1'b0;
      tick(); #1;
      checkVal("wr_mWe_off", mWe[1],     0);
      checkVal("wr_rvalid2", dRValid[1], 0);
      dWe = 1'b0; dBe = 4'hF;

      // Starvation, STARVE_MAX=4, RD_LAT=1
      resetPulse();
      iReq = 1'b1; iAddr = 32'h0040_0000;
      dReq = 1'b1; dAddr = 32'h1001_0000;
      for (int c = 0; c < 7; c++) begin
         #1;
         checkVal($sformatf("stv_dGnt_c%0d", c), dGnt[1], expD[c]);
         checkVal($sformatf("stv_iGnt_c%0d", c), iGnt[1], expI[c]);
         tick();
      end

      // Reset in T+1 of an RD_LAT=3 D read
      resetPulse();
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0000;
      #1;
      checkVal("l3_dGnt", dGnt[3], 1);
      tick();
      dReq = 1'b0;
      for (int c = 0; c < 3; c++) tick();
      #1;
      checkVal("l3_dRValid", dRValid[3], 1);
      checkVal("l3_dRData",  dRData[3],  32'hCAFE_F00D);
      dReq = 1'b1; iReq = 1'b1; iAddr = 32'h0040_0000;
      #1;
      checkVal("mr_dGnt", dGnt[3], 1);
      tick();
      rst = 1'b1;
      #1;
      checkVal("mr_busy", busy[3], 1);
`ifdef ARB_PERF_CNT_EN
      checkVal("mr_iStall_pre", iStall[3], 1);
      checkVal("mr_dStall_pre", dStall[3], 0);
`endif
      tick();
      rst = 1'b0; iReq = 1'b0; dReq = 1'b0;
      #1;
      checkVal("mr_dRData", dRData[3], 0);
      checkVal("mr_busy0",  busy[3],   0);
`ifdef ARB_PERF_CNT_EN
      checkVal("mr_iStall_post", iStall[3], 0);
`endif
      for (int c = 0; c < 5; c++) begin
         checkVal($sformatf("mr_noRValid_c%0d", c), dRValid[3], 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
